nibble_serial_alu: RTL and testbench
====================================

Name: nibble_serial_alu

Overview:
Multi-cycle WIDTH-bit ALU that reuses one bit4_look_ahead_carry_adder slice, processing one nibble per clock from LSB to MSB with a registered carry between nibbles. It sits in the EX stage of the MIPS32 core as the area-reduced integer ALU. Its job is to consume the slice's S/C/AND/OR/XOR outputs and assemble a full-width result plus flags. Operations are started by a START pulse and completed by a one-cycle DONE pulse.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4 and at least 8
NIB, WIDTH/4, number of nibble cycles (localparam, not overridable)

Ports:
CLK_in  input  1  clock; all state updates on rising edge
RST_in  input  1  synchronous, active-high reset
START_in  input  1  request; sampled only in IDLE or DONE state
OP_in  input  3  operation code, latched with START
A_in  input  WIDTH  operand A, latched with START
B_in  input  WIDTH  operand B, latched with START
BUSY_out  output  1  high while nibbles are being processed
DONE_out  output  1  one-cycle pulse; RESULT/flags valid from this cycle
RESULT_out  output  WIDTH  result; held until the next accepted START
C_out  output  1  carry out of MSB (ADD/SUB only; SUB: 1 = no borrow)
V_out  output  1  signed overflow (ADD/SUB only)
Z_out  output  1  RESULT_out == 0

Behaviour:
- Clock and reset: one clock (CLK_in); reset is synchronous and active-high (RST_in).
- Reset: state=IDLE; all outputs 0; internal shift registers, carry and count cleared.
- OP encoding:
  - 000 ADD; 001 SUB (B inverted, carry-in 1)
  - 010 AND; 011 OR; 100 XOR; 101 NOR (inverted OR lane)
  - 110 SLT; 111 SLTU (both run as SUB internally)
- States: IDLE -> RUN on START; RUN -> FIN after nibble NIB-1; FIN -> RUN on START, else -> IDLE.
- DONE_out is high exactly in FIN.
- Timing: START sampled at edge t latches operands and OP, sets count=0 and carry=(SUB|SLT|SLTU).
  - Cycles t+1..t+NIB: BUSY_out=1; slice fed A_sh[3:0], B_sh[3:0] (inverted for SUB-class) and the carry register.
  - Each edge: selected lane shifted into result MSB nibble; A_sh/B_sh shifted right by 4; carry <= slice C_out; count++.
  - DONE_out=1 in cycle t+NIB+1. Latency from START to DONE: NIB+1 cycles (9 for WIDTH=32).
- Final flags, registered at the last-nibble edge:
  - C_out = final carry for ADD/SUB, else 0.
  - V_out = (a_msb ~^ b'_msb) & (s_msb ^ a_msb) for ADD/SUB, else 0; b' = post-inversion B.
  - SLT: RESULT = {0..., s_msb ^ V}. SLTU: RESULT = {0..., ~carry}. C_out=V_out=0 for both.
  - Z_out computed on final RESULT.
- During RUN, RESULT_out/flags show partial values and must not be consumed. Only DONE marks validity.
- START while BUSY_out=1: ignored; the operation in flight is unaffected.
- START in FIN: accepted; back-to-back throughput is one op per NIB+1 cycles.
- RST_in mid-RUN: abort at that edge; IDLE; outputs 0; no DONE pulse.
- Reserved/unused: none; all 8 OP codes are defined.
- Arithmetic is modulo 2^WIDTH; no exceptions are raised (the trap on overflow is the decode stage's job).

Decomposition:
- Shared package alu_pkg: OP_* localparam codes (3-bit) and state encodings IDLE/RUN/FIN.
- The MIPS funct-to-OP mapping also lives in alu_pkg.
- Single sub-module: instantiate the existing bit4_look_ahead_carry_adder as the nibble datapath; no new sub-modules.

Test Plan:
- ADD A=0x00000009, B=0x00000003 -> DONE at START+9 cycles; RESULT=0x0000000C; C=0, V=0, Z=0.
- ADD A=0x7FFFFFFF, B=0x00000001 -> RESULT=0x80000000; V=1, C=0. ADD 0xFFFFFFFF+0x00000001 -> RESULT=0, C=1, Z=1, V=0.
- SUB 0x00000005-0x00000007 -> RESULT=0xFFFFFFFE, C=0. SLT same operands -> 0x00000001. SLTU 0xFFFFFFFF vs 0x00000001 -> 0x00000000.
- AND/OR/XOR/NOR with A=0xF0F0A5A5, B=0x0FF0FF00 -> 0x00F0A500 / 0xFFF0FFA5 / 0xFF005AA5 / 0x000F005A; C=V=0.
- START pulsed at cycles 3 and 5 of an op -> ignored; single DONE; result from the first operands. START held through FIN -> new op starts; DONE pulses spaced 9 cycles apart.
- RST_in asserted at cycle 4 of a RUN -> next cycle IDLE; BUSY/DONE/RESULT/flags all 0; no DONE pulse; a later START completes normally.

Source files
------------

// File: rtl/nibble_serial_alu_pkg.sv
// Shared ALU definitions: 3-bit operation codes, sequencer state encoding,
// and the MIPS R-type funct to ALU operation mapping.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // ADDU/SUBU share datapaths with ADD/SUB; overflow trapping is decided in decode.
  function automatic logic [2:0] funct_to_op(input logic [5:0] funct);
    case (funct)
      6'h20, 6'h21: funct_to_op = OP_ADD;
      6'h22, 6'h23: funct_to_op = OP_SUB;
      6'h24:        funct_to_op = OP_AND;
      6'h25:        funct_to_op = OP_OR;
      6'h26:        funct_to_op = OP_XOR;
      6'h27:        funct_to_op = OP_NOR;
      6'h2a:        funct_to_op = OP_SLT;
      6'h2b:        funct_to_op = OP_SLTU;
      default:      funct_to_op = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/bit4_look_ahead_carry_adder.sv
// 4-bit carry-lookahead adder slice that also exposes the bitwise AND/OR/XOR
// lanes, so one slice serves every ALU operation.
module bit4_look_ahead_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic [3:0] and_v,
  output logic [3:0] or_v,
  output logic [3:0] xor_v
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum   = p ^ c[3:0];
  assign cout  = c[4];
  assign and_v = g;
  assign or_v  = a | b;
  assign xor_v = p;

endmodule

// File: rtl/nibble_serial_alu.sv
// Area-reduced WIDTH-bit ALU: one 4-bit slice processes a nibble per clock,
// LSB first, with the carry held in a register between nibbles.
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK_in,
  input  logic             RST_in,
  input  logic             START_in,
  input  logic [2:0]       OP_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             BUSY_out,
  output logic             DONE_out,
  output logic [WIDTH-1:0] RESULT_out,
  output logic             C_out,
  output logic             V_out,
  output logic             Z_out
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  // Handshake: START_in is taken only in IDLE or FIN (a one-cycle accept);
  // while BUSY_out is high it is ignored. DONE_out pulses for exactly one
  // cycle, and RESULT_out/flags are valid from then until the next accept.

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, result_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry, c_q, v_q, z_q;

  logic       accept, last, sub_class, arith;
  logic [3:0] b_nib, sum, and_v, or_v, xor_v, lane;
  logic       cout, v_calc;
  logic [WIDTH-1:0] final_res;

  bit4_look_ahead_carry_adder u_slice (
    .a     (a_sh[3:0]),
    .b     (b_nib),
    .cin   (carry),
    .sum   (sum),
    .cout  (cout),
    .and_v (and_v),
    .or_v  (or_v),
    .xor_v (xor_v)
  );

  assign sub_class = (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SLTU);
  assign arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign b_nib     = sub_class ? ~b_sh[3:0] : b_sh[3:0];
  assign last      = (cnt == CW'(NIB - 1));
  assign accept    = START_in && ((state == IDLE) || (state == FIN));
  // Only meaningful on the MSB nibble, where a_sh/b_nib/sum hold the sign bits.
  assign v_calc    = (a_sh[3] ~^ b_nib[3]) & (sum[3] ^ a_sh[3]);

  always_comb begin
    lane = sum;
    case (op_q)
      OP_AND:  lane = and_v;
      OP_OR:   lane = or_v;
      OP_XOR:  lane = xor_v;
      OP_NOR:  lane = ~or_v;
      default: lane = sum;
    endcase
  end

  always_comb begin
    final_res = {lane, result_q[WIDTH-1:4]};
    if (op_q == OP_SLT) begin
      final_res    = '0;
      final_res[0] = sum[3] ^ v_calc;
    end else if (op_q == OP_SLTU) begin
      final_res    = '0;
      final_res[0] = ~cout;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START_in) state_nxt = RUN;
      RUN:     if (last) state_nxt = FIN;
      FIN:     state_nxt = START_in ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      result_q <= '0;
      op_q     <= OP_ADD;
      cnt      <= '0;
      carry    <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sh     <= A_in;
        b_sh     <= B_in;
        op_q     <= OP_in;
        cnt      <= '0;
        carry    <= (OP_in == OP_SUB) || (OP_in == OP_SLT) || (OP_in == OP_SLTU);
        result_q <= '0;
        c_q      <= 1'b0;
        v_q      <= 1'b0;
        z_q      <= 1'b0;
      end else if (state == RUN) begin
        a_sh  <= {4'b0, a_sh[WIDTH-1:4]};
        b_sh  <= {4'b0, b_sh[WIDTH-1:4]};
        carry <= cout;
        cnt   <= cnt + 1'b1;
        if (last) begin
          result_q <= final_res;
          c_q      <= arith & cout;
          v_q      <= arith & v_calc;
          z_q      <= (final_res == '0);
        end else begin
          result_q <= {lane, result_q[WIDTH-1:4]};
        end
      end
    end
  end

  assign BUSY_out   = (state == RUN);
  assign DONE_out   = (state == FIN);
  assign RESULT_out = result_q;
  assign C_out      = c_q;
  assign V_out      = v_q;
  assign Z_out      = z_q;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed bench for nibble_serial_alu: a vector table for every operation
// plus hand-written sequences for START during RUN, back-to-back ops and reset.
module tb_nibble_serial_alu;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, c_f, v_f, z_f;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    logic         exp_c;
    logic         exp_v;
    logic         exp_z;
  } vec_t;

  vec_t vecs[$];

  nibble_serial_alu #(.WIDTH(W)) dut (
    .CLK_in     (clk),
    .RST_in     (rst),
    .START_in   (start),
    .OP_in      (op),
    .A_in       (a),
    .B_in       (b),
    .BUSY_out   (busy),
    .DONE_out   (done),
    .RESULT_out (result),
    .C_out      (c_f),
    .V_out      (v_f),
    .Z_out      (z_f)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one op and waits (bounded) for DONE; returns the cycle count.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_cycles = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = cyc;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, n_done, t1, t2, cyc;

    vecs.push_back('{OP_ADD,  32'h00000009, 32'h00000003, 32'h0000000C, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_SUB,  32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{OP_SUB,  32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{OP_SLT,  32'h00000005, 32'h00000007, 32'h00000001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_SLT,  32'h00000007, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_AND,  32'hF0F0A5A5, 32'h0FF0FF00, 32'h00F0A500, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_OR,   32'hF0F0A5A5, 32'h0FF0FF00, 32'hFFF0FFA5, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_XOR,  32'hF0F0A5A5, 32'h0FF0FF00, 32'hFF005AA5, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_NOR,  32'hF0F0A5A5, 32'h0FF0FF00, 32'h000F005A, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_AND,  32'h0000FFFF, 32'hFFFF0000, 32'h00000000, 1'b0, 1'b0, 1'b1});

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_result", result,      32'd0);
    check("reset_flags",  32'({c_f, v_f, z_f}), 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(LAT - 1));
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_r);
      check($sformatf("vec%0d_c", i), 32'(c_f), 32'(vecs[i].exp_c));
      check($sformatf("vec%0d_v", i), 32'(v_f), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_z", i), 32'(z_f), 32'(vecs[i].exp_z));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // START pulsed during RUN must not disturb the op in flight.
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 32'h9; b = 32'h3;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0; lat = 0;
    for (cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      if (cyc == 3 || cyc == 5) begin
        start = 1'b1; op = OP_AND; a = 32'h0; b = 32'h0;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        if (lat == 0) begin
          lat = cyc;
          check("ignored_start_result", result, 32'h0000000C);
        end
      end
    end
    start = 1'b0;
    check("ignored_start_latency", 32'(lat), 32'(LAT));
    check("ignored_start_done_count", 32'(n_done), 32'd1);

    // START held through FIN: second op is taken at the DONE edge.
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 32'h10; b = 32'h3;
    @(posedge clk);
    #1 a = 32'h20;
    t1 = 0; t2 = 0;
    for (cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (done && t1 == 0) begin
        t1 = cyc;
        check("b2b_first_result", result, 32'h00000013);
      end else if (done && t2 == 0) begin
        t2 = cyc;
        start = 1'b0;
        check("b2b_second_result", result, 32'h00000023);
      end
    end
    start = 1'b0;
    check("b2b_first_latency", 32'(t1), 32'(LAT));
    check("b2b_spacing", 32'(t2 - t1), 32'(LAT));

    // Reset mid-RUN aborts without a DONE pulse.
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 32'h11111111; b = 32'h22222222;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_done",   32'(done), 32'd0);
    check("abort_result", result,    32'd0);
    check("abort_flags",  32'({c_f, v_f, z_f}), 32'd0);
    n_done = 0;
    for (cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort_no_activity", 32'(n_done), 32'd0);
    run_op(OP_ADD, 32'h11111111, 32'h22222222, lat, bc);
    check("after_abort_latency", 32'(lat), 32'(LAT));
    check("after_abort_result", result, 32'h33333333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
